instr_exec_ctrl: RTL

INSTR_EXEC_CTRL -- requirements
Module: instr_exec_ctrl

---
 rtl/exec_pkg.sv | 54 +++++
 rtl/exec_alu.sv | 48 ++++
 rtl/instr_exec_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the instruction execution controller: opcodes, field widths, FSM states.
// Optional feature macro: EXEC_MUL_EN (opcode D becomes a legal multiply).
package exec_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int REG_W  = 2;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_MOV = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_AND = 4'h4;
  localparam logic [OP_W-1:0] OP_OR  = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR = 4'h6;
  localparam logic [OP_W-1:0] OP_NOT = 4'h7;
  localparam logic [OP_W-1:0] OP_SHL = 4'h8;
  localparam logic [OP_W-1:0] OP_SHR = 4'h9;
  localparam logic [OP_W-1:0] OP_INC = 4'hA;
  localparam logic [OP_W-1:0] OP_DEC = 4'hB;
  localparam logic [OP_W-1:0] OP_CMP = 4'hC;
  localparam logic [OP_W-1:0] OP_MUL = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
  } instr_t;

  // Opcodes above the last defined one retire as illegal.
  function automatic logic op_defined(input logic [OP_W-1:0] op);
`ifdef EXEC_MUL_EN
    return (op <= OP_MUL);
`else
    return (op <= OP_CMP);
`endif
  endfunction

  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return op_defined(op) && (op != OP_NOP) && (op != OP_CMP);
  endfunction

  function automatic logic op_sets_flags(input logic [OP_W-1:0] op);
    return op_defined(op) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: all arithmetic, logic and shift operations plus zero/carry flags.
// Opcode D multiplies only when EXEC_MUL_EN is defined.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic [OP_W-1:0] op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   result,
  output logic            z,
  output logic            c
);

  // Bit DW of the widened result carries the carry, borrow or shifted-out bit.
  logic [DW:0] wide;
`ifdef EXEC_MUL_EN
  logic [2*DW-1:0] prod;
  assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
`endif

  always_comb begin
    wide = '0;
    case (op)
      OP_MOV:         wide = {1'b0, b};
      OP_ADD:         wide = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_CMP: wide = {1'b0, a} - {1'b0, b};
      OP_AND:         wide = {1'b0, a & b};
      OP_OR:          wide = {1'b0, a | b};
      OP_XOR:         wide = {1'b0, a ^ b};
      OP_NOT:         wide = {1'b0, ~b};
      OP_SHL:         wide = {a, 1'b0};
      OP_SHR:         wide = {a[0], 1'b0, a[DW-1:1]};
      OP_INC:         wide = {1'b0, a} + {{DW{1'b0}}, 1'b1};
      OP_DEC:         wide = {1'b0, a} - {{DW{1'b0}}, 1'b1};
`ifdef EXEC_MUL_EN
      OP_MUL:         wide = {1'b0, prod[DW-1:0]};
`endif
      default:        wide = '0;
    endcase
  end

  assign result = wide[DW-1:0];
  assign c      = wide[DW];
  assign z      = (wide[DW-1:0] == '0);

endmodule

// File: rtl/instr_exec_ctrl.sv
// Four-state instruction execution controller: accept, read operands, execute, write back.
// Build option: define EXEC_MUL_EN to make opcode D a legal multiply.
module instr_exec_ctrl
  import exec_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [DW-1:0] R0,
  input  logic [DW-1:0] R1,
  input  logic [DW-1:0] R2,
  input  logic [DW-1:0] R3,
  output logic [DW-1:0] res_alu,
  output logic [1:0]    res_dest,
  output logic          enact,
  output logic          flag_z,
  output logic          flag_c,
  output logic          done,
  output logic          illegal
);

  state_t          state;
  instr_t          instr_reg;
  logic [DW-1:0]   a_reg;
  logic [DW-1:0]   b_reg;
  logic [DW-1:0]   rd_val;
  logic [DW-1:0]   rs_val;
  logic [DW-1:0]   alu_result;
  logic            alu_z;
  logic            alu_c;
  logic            op_wr;
  logic            op_flags;
  logic            op_def;

  always_comb begin
    rd_val = R0;
    case (instr_reg.rd)
      2'd0:    rd_val = R0;
      2'd1:    rd_val = R1;
      2'd2:    rd_val = R2;
      default: rd_val = R3;
    endcase
  end

  always_comb begin
    rs_val = R0;
    case (instr_reg.rs)
      2'd0:    rs_val = R0;
      2'd1:    rs_val = R1;
      2'd2:    rs_val = R2;
      default: rs_val = R3;
    endcase
  end

  assign op_wr    = op_writes(instr_reg.op);
  assign op_flags = op_sets_flags(instr_reg.op);
  assign op_def   = op_defined(instr_reg.op);

  exec_alu #(.DW(DW)) u_alu (
    .op     (instr_reg.op),
    .a      (a_reg),
    .b      (b_reg),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      instr_reg   <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      instr_ready <= 1'b1;
      res_alu     <= '0;
      res_dest    <= '0;
      enact       <= 1'b1;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      enact   <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_reg   <= instr;
            instr_ready <= 1'b0;
            state       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_reg <= rd_val;
          b_reg <= rs_val;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          // Outputs are registered here so they are already valid throughout WB.
          if (op_wr) begin
            res_alu  <= alu_result;
            res_dest <= instr_reg.rd;
            enact    <= 1'b0;
          end
          if (op_flags) begin
            flag_z <= alu_z;
            flag_c <= alu_c;
          end
          done    <= 1'b1;
          illegal <= !op_def;
          state   <= ST_WB;
        end
        ST_WB: begin
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
